// File: rtl/mul_seq.sv
// Sequential shift-add multiplier, W-bit operands, 2W-bit product, signed/unsigned per operation.
// The block has no adder of its own; every addition goes through the shared sum_in_a/sum_in_b/sum_out port.
//
// state | meaning
// IDLE  | waiting for start; shared adder inputs held at zero
// NEG   | one cycle forming the negated MSB partial product for signed negative b
// SUM   | one cycle per multiplier bit, accumulating into result
module mul_seq #(
  parameter int W     = 8,
  parameter int CTR_W = $clog2(W)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [W-1:0]   a_i,
  input  logic [W-1:0]   b_i,
  input  logic           signed_i,
  output logic           busy,
  output logic           done,
  output logic [2*W-1:0] result,
  output logic [2*W-1:0] sum_in_a,
  output logic [2*W-1:0] sum_in_b,
  input  logic [2*W-1:0] sum_out
);

  localparam int W2 = 2 * W;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_NEG  = 2'd1,
    S_SUM  = 2'd2
  } state_t;

  state_t            state, state_n;
  logic [W-1:0]      a_q, b_q;
  logic              sgn_q;
  logic [W2-1:0]     pp;
  logic [CTR_W-1:0]  ctr;
  logic [W2-1:0]     a_ext;
  logic              last_bit;

  assign a_ext    = sgn_q ? {{W{a_q[W-1]}}, a_q} : {{W{1'b0}}, a_q};
  assign last_bit = (ctr == CTR_W'(W - 1));
  assign busy     = (state != S_IDLE);

  always_comb begin
    state_n  = state;
    sum_in_a = '0;
    sum_in_b = '0;
    case (state)
      S_IDLE: begin
        if (start)
          state_n = (signed_i && b_i[W-1]) ? S_NEG : S_SUM;
      end
      S_NEG: begin
        // Two's-complement negate of a_ext<<(W-1): invert here, +1 via operand B.
        sum_in_a = ~(a_ext << (W - 1));
        sum_in_b = W2'(1);
        state_n  = S_SUM;
      end
      S_SUM: begin
        sum_in_b = result;
        if (!b_q[ctr])
          sum_in_a = '0;
        else if (last_bit && sgn_q)
          sum_in_a = pp;
        else
          sum_in_a = a_ext << ctr;
        if (last_bit)
          state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      a_q    <= '0;
      b_q    <= '0;
      sgn_q  <= 1'b0;
      pp     <= '0;
      ctr    <= '0;
      result <= '0;
      done   <= 1'b0;
    end else begin
      state <= state_n;
      done  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            a_q    <= a_i;
            b_q    <= b_i;
            sgn_q  <= signed_i;
            result <= '0;
            ctr    <= '0;
          end
        end
        S_NEG: pp <= sum_out;
        S_SUM: begin
          result <= sum_out;
          ctr    <= ctr + 1'b1;
          if (last_bit)
            done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_seq.sv
// Directed bench for mul_seq at W=8 and W=16; the shared adder is modelled here as a plain 2W-bit add.
module tb_mul_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        start8 = 1'b0, s8 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic        busy8, done8;
  logic [15:0] res8, sa8, sb8, so8;

  logic        start16 = 1'b0, s16 = 1'b0;
  logic [15:0] a16 = '0, b16 = '0;
  logic        busy16, done16;
  logic [31:0] res16, sa16, sb16, so16;

  assign so8  = sa8 + sb8;
  assign so16 = sa16 + sb16;

  mul_seq #(.W(8)) u8 (
    .clk(clk), .rst(rst), .start(start8), .a_i(a8), .b_i(b8), .signed_i(s8),
    .busy(busy8), .done(done8), .result(res8),
    .sum_in_a(sa8), .sum_in_b(sb8), .sum_out(so8)
  );

  mul_seq #(.W(16)) u16 (
    .clk(clk), .rst(rst), .start(start16), .a_i(a16), .b_i(b16), .signed_i(s16),
    .busy(busy16), .done(done16), .result(res16),
    .sum_in_a(sa16), .sum_in_b(sb16), .sum_out(so16)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Returns just after the edge on which done is first seen (the done cycle).
  task automatic run8(input string tag, input logic [7:0] a, input logic [7:0] b, input logic s,
                      input logic [15:0] exp, input int lat, input logic chk_sums,
                      input logic [15:0] neg_a);
    int n = 1;
    int busy_cnt = 0;
    @(negedge clk);
    a8 = a; b8 = b; s8 = s; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    while (!done8 && n < 40) begin
      if (busy8) busy_cnt++;
      if (neg_a != 16'h0 && n == 1) begin
        check({tag, "_neg_a"}, {16'h0, sa8}, {16'h0, neg_a});
        check({tag, "_neg_b"}, {16'h0, sb8}, 32'h1);
      end
      if (chk_sums && n <= 8)
        check({tag, "_sum_a"}, {16'h0, sa8}, b[n-1] ? ({8'h0, a} << (n - 1)) : 32'h0);
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_done"}, {31'h0, done8}, 32'h1);
    check({tag, "_result"}, {16'h0, res8}, {16'h0, exp});
    check({tag, "_latency"}, n, lat);
    check({tag, "_busy_cycles"}, busy_cnt, lat - 1);
  endtask

  task automatic run16(input string tag, input logic [15:0] a, input logic [15:0] b, input logic s,
                       input logic [31:0] exp, input int lat);
    int n = 1;
    @(negedge clk);
    a16 = a; b16 = b; s16 = s; start16 = 1'b1;
    @(posedge clk); #1;
    start16 = 1'b0;
    while (!done16 && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_result"}, res16, exp);
    check({tag, "_latency"}, n, lat);
  endtask

  initial begin
    #2;
    check("rst_result", {16'h0, res8}, 32'h0);
    check("rst_busy", {31'h0, busy8}, 32'h0);
    check("rst_done", {31'h0, done8}, 32'h0);
    check("rst_sum_a", {16'h0, sa8}, 32'h0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    run8("u13x11", 8'h0D, 8'h0B, 1'b0, 16'h008F, 9, 1'b1, 16'h0);
    @(posedge clk); #1;
    check("done_pulse", {31'h0, done8}, 32'h0);
    check("result_hold", {16'h0, res8}, 32'h008F);
    check("idle_sum_a", {16'h0, sa8}, 32'h0);
    check("idle_sum_b", {16'h0, sb8}, 32'h0);

    run8("uffxff", 8'hFF, 8'hFF, 1'b0, 16'hFE01, 9, 1'b1, 16'h0);
    run8("b2b_0xff", 8'h00, 8'hFF, 1'b0, 16'h0000, 9, 1'b1, 16'h0);

    run8("sm3x5", 8'hFD, 8'h05, 1'b1, 16'hFFF1, 9, 1'b0, 16'h0);
    run8("s5xm3", 8'h05, 8'hFD, 1'b1, 16'hFFF1, 10, 1'b0, 16'hFD7F);
    run8("s80x80", 8'h80, 8'h80, 1'b1, 16'h4000, 10, 1'b0, 16'h3FFF);
    run8("u80x80", 8'h80, 8'h80, 1'b0, 16'h4000, 9, 1'b1, 16'h0);
    run8("s80x01", 8'h80, 8'h01, 1'b1, 16'hFF80, 9, 1'b0, 16'h0);

    // Start while busy must be ignored.
    @(negedge clk);
    a8 = 8'd3; b8 = 8'd7; s8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    @(negedge clk); @(negedge clk);
    a8 = 8'd9; b8 = 8'd9; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    for (int i = 0; i < 20 && !done8; i++) @(negedge clk);
    check("ignore_done", {31'h0, done8}, 32'h1);
    check("ignore_result", {16'h0, res8}, 32'h0015);

    // Asynchronous abort mid-operation.
    @(negedge clk);
    a8 = 8'hAA; b8 = 8'h55; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (4) @(negedge clk);
    check("pre_abort_busy", {31'h0, busy8}, 32'h1);
    rst = 1'b1;
    #1;
    check("abort_busy", {31'h0, busy8}, 32'h0);
    check("abort_result", {16'h0, res8}, 32'h0);
    check("abort_done", {31'h0, done8}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    run8("after_rst_2x3", 8'd2, 8'd3, 1'b0, 16'h0006, 9, 1'b1, 16'h0);

    run16("u16_ffff", 16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE0001, 17);
    run16("s16_8000x7fff", 16'h8000, 16'h7FFF, 1'b1, 32'hC0008000, 17);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
